// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each requester has a one-entry result register that accepts a new result in the cycle it is popped.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_c,
  output logic              resp0_zero,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_c,
  output logic              resp1_zero,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zero,
  output logic              busy
);

  logic rr;
  logic elig0, elig1;
  logic grant0, grant1;

  // grant stage: a requester may issue only if its result slot is empty or being popped now
  always_comb begin
    elig0  = rstn && req0_valid && (!resp0_valid || resp0_ready);
    elig1  = rstn && req1_valid && (!resp1_valid || resp1_ready);
    grant0 = elig0 && (!elig1 || !rr);
    grant1 = elig1 && (!elig0 || rr);
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (grant0) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (grant1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = resp0_valid | resp1_valid;

  // result stage: capture the ALU output into the granted requester's slot
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr          <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_c     <= '0;
      resp0_zero  <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_c     <= '0;
      resp1_zero  <= 1'b0;
    end else begin
      if (grant0)      rr <= 1'b1;
      else if (grant1) rr <= 1'b0;

      if (grant0) begin
        resp0_valid <= 1'b1;
        resp0_c     <= alu_c;
        resp0_zero  <= alu_zero;
      end else if (resp0_valid && resp0_ready) begin
        resp0_valid <= 1'b0;
      end

      if (grant1) begin
        resp1_valid <= 1'b1;
        resp1_c     <= alu_c;
        resp1_zero  <= alu_zero;
      end else if (resp1_valid && resp1_ready) begin
        resp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU and per-requester result scoreboards.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 2;

  logic              clk, rstn;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic              resp0_ready, resp1_ready;
  logic [DATA_W-1:0] resp0_c, resp1_c;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic [OP_W-1:0]   alu_op;
  logic              alu_zero, busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] q0[$];
  logic [DATA_W:0] q1[$];

  function automatic logic [DATA_W:0] alu_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0] op);
    logic [DATA_W-1:0] c;
    case (op)
      2'b00:   c = a + b;
      2'b01:   c = a - b;
      default: c = a | b;
    endcase
    return {(c == '0), c};
  endfunction

  assign {alu_zero, alu_c} = alu_model(alu_a, alu_b, alu_op);

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_c(resp0_c), .resp0_zero(resp0_zero), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_c(resp1_c), .resp1_zero(resp1_zero), .resp1_ready(resp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  // One clock: check the expected grant mid-cycle, push expected results, then pop/compare after the edge.
  task automatic cycle(input logic g0, input logic g1);
    logic [DATA_W:0] e;
    @(negedge clk);
    check("req0_ready", {32'd0, req0_ready}, {32'd0, g0});
    check("req1_ready", {32'd0, req1_ready}, {32'd0, g1});
    if (g0) begin
      q0.push_back(alu_model(req0_a, req0_b, req0_op));
      check("alu_a_g0", {1'b0, alu_a}, {1'b0, req0_a});
      check("alu_op_g0", {31'd0, alu_op}, {31'd0, req0_op});
    end else if (g1) begin
      q1.push_back(alu_model(req1_a, req1_b, req1_op));
      check("alu_b_g1", {1'b0, alu_b}, {1'b0, req1_b});
      check("alu_op_g1", {31'd0, alu_op}, {31'd0, req1_op});
    end else begin
      check("alu_a_idle", {1'b0, alu_a}, '0);
      check("alu_op_idle", {31'd0, alu_op}, '0);
    end
    @(posedge clk); #1;
    if (g0) begin
      if (q0.size() == 0) check("q0_empty", 33'd1, 33'd0);
      else begin
        e = q0.pop_front();
        check("resp0_result", {resp0_zero, resp0_c}, e);
        check("resp0_valid", {32'd0, resp0_valid}, 33'd1);
      end
    end
    if (g1) begin
      if (q1.size() == 0) check("q1_empty", 33'd1, 33'd0);
      else begin
        e = q1.pop_front();
        check("resp1_result", {resp1_zero, resp1_c}, e);
        check("resp1_valid", {32'd0, resp1_valid}, 33'd1);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req0(1'b1, 32'd9, 32'd9, 2'b01);
    set_req1(1'b1, 32'hF0, 32'h0F, 2'b10);

    // reset: no grants, cleared result registers
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", {32'd0, req0_ready}, '0);
    check("rst_req1_ready", {32'd0, req1_ready}, '0);
    check("rst_alu_a", {1'b0, alu_a}, '0);
    @(posedge clk); #1;
    check("rst_resp0", {resp0_valid, resp0_zero, resp0_c}, '0);
    check("rst_resp1", {resp1_valid, resp1_zero, resp1_c}, '0);
    check("rst_busy", {32'd0, busy}, '0);

    // contention right after reset: rr=0 prefers req0, then alternates
    rstn = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("cont_resp1_c", {1'b0, resp1_c}, 33'hFF);
    req1_valid = 1'b0;
    cycle(1'b1, 1'b0);

    // single request, rr points at req1 but only req0 is eligible
    set_req0(1'b1, 32'd5, 32'd3, 2'b00);
    cycle(1'b1, 1'b0);
    check("single_c", {resp0_zero, resp0_c}, {1'b0, 32'd8});

    // backpressure on requester 1
    resp1_ready = 1'b0;
    req0_valid = 1'b0;
    set_req1(1'b1, 32'd7, 32'd1, 2'b01);
    cycle(1'b0, 1'b1);
    set_req1(1'b1, 32'd2, 32'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      set_req0(1'b1, 32'd10 + i, 32'd3 * i, i[1:0]);
      cycle(1'b1, 1'b0);
      check("bp_resp1_c", {resp1_valid, resp1_c}, {1'b1, 32'd6});
      check("bp_busy", {32'd0, busy}, 33'd1);
    end
    resp1_ready = 1'b1;
    req0_valid = 1'b0;
    cycle(1'b0, 1'b1);
    check("bp_refill_c", {1'b0, resp1_c}, 33'd4);

    // full throughput alternation
    for (int i = 0; i < 6; i++) begin
      set_req0(1'b1, 32'd100 + i, 32'd7 * i, 2'b00);
      set_req1(1'b1, 32'hFFFF_FFF0, 32'd5 + i, 2'b01);
      cycle(i % 2 == 0, i % 2 == 1);
      check("thr_busy", {32'd0, busy}, 33'd1);
    end

    // pop-and-refill on requester 0, then plain pop keeps data
    req1_valid = 1'b0;
    set_req0(1'b1, 32'd4, 32'd4, 2'b10);
    cycle(1'b1, 1'b0);
    set_req0(1'b1, 32'd1, 32'd2, 2'b00);
    cycle(1'b1, 1'b0);
    check("refill_c", {resp0_valid, resp0_c}, {1'b1, 32'd3});
    req0_valid = 1'b0;
    cycle(1'b0, 1'b0);
    check("pop_hold", {resp0_valid, resp0_c}, {1'b0, 32'd3});
    check("pop_busy", {32'd0, busy}, '0);

    // mid-operation reset with a stalled result in slot 1 and rr pointing at req1
    resp1_ready = 1'b0;
    set_req1(1'b1, 32'd1, 32'd1, 2'b00);
    cycle(1'b0, 1'b1);
    set_req0(1'b1, 32'd3, 32'd3, 2'b01);
    cycle(1'b1, 1'b0);
    check("pre_rst_busy", {resp1_valid, busy}, {31'd0, 2'b11});
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, req0_ready, req1_ready}, '0);
    check("mid_rst_alu_op", {31'd0, alu_op}, '0);
    @(posedge clk); #1;
    check("mid_rst_resp1", {resp1_valid, resp1_c}, '0);
    check("mid_rst_busy", {31'd0, busy, resp0_valid}, '0);
    rstn = 1'b1;
    resp1_ready = 1'b1;
    cycle(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
